// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one fetch at a time over a
// req/gnt/rvalid bus, and hands fetched words to decode through a one-entry buffer.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]  state_q, state_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] fetch_pc_q, fetch_pc_next;
    logic        squash_q, squash_next;
    logic        valid_q, valid_next;
    logic [31:0] instr_q, instr_next;
    logic [31:0] instr_pc_q, instr_pc_next;

    logic        req;
    logic        grant;
    logic        rsp;
    logic [31:0] redirect_pc;

    // Requests are gated so a new word is only fetched when the buffer will have room.
    assign req         = (state_q == ST_REQ) && (!valid_q || instr_ready_i);
    assign grant       = req && imem_gnt_i;
    assign rsp         = (state_q == ST_WAIT) && imem_rvalid_i;
    assign redirect_pc = branch_target_i & 32'hFFFF_FFFC;

    always_comb begin
        state_next    = state_q;
        pc_next       = pc_q;
        fetch_pc_next = fetch_pc_q;
        squash_next   = squash_q;
        valid_next    = valid_q;
        instr_next    = instr_q;
        instr_pc_next = instr_pc_q;

        if (valid_q && instr_ready_i) begin
            valid_next = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                if (grant) begin
                    state_next    = ST_WAIT;
                    fetch_pc_next = pc_q;
                    squash_next   = branch_taken_i;
                end
            end
            ST_WAIT: begin
                if (rsp) begin
                    state_next  = ST_REQ;
                    squash_next = 1'b0;
                    if (!squash_q && !branch_taken_i) begin
                        valid_next    = 1'b1;
                        instr_next    = imem_rdata_i;
                        instr_pc_next = fetch_pc_q;
                        pc_next       = fetch_pc_q + 32'd4;
                    end
                end else if (branch_taken_i) begin
                    squash_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A redirect overrides any load or consume decided above.
        if (branch_taken_i) begin
            pc_next    = redirect_pc;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            squash_q   <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else begin
            state_q    <= state_next;
            pc_q       <= pc_next;
            fetch_pc_q <= fetch_pc_next;
            squash_q   <= squash_next;
            valid_q    <= valid_next;
            instr_q    <= instr_next;
            instr_pc_q <= instr_pc_next;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: a bus model plus an in-order instruction-stream
// scoreboard, driven by directed scenarios followed by a randomized run.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;

    // Second instance with a reset PC at the top of the address space.
    logic        b_rst_n = 1'b0;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_gnt = 1'b0;
    logic        b_rvalid = 1'b0;
    logic [31:0] b_rdata = 32'd0;
    logic        b_valid;
    logic [31:0] b_instr;
    logic [31:0] b_instr_pc;
    logic        b_ready = 1'b0;
    logic        b_branch = 1'b0;
    logic [31:0] b_target = 32'd0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i)
    );

    fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
        .clk_i(clk), .rst_ni(b_rst_n),
        .imem_req_o(b_req), .imem_addr_o(b_addr),
        .imem_gnt_i(b_gnt), .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
        .instr_valid_o(b_valid), .instr_o(b_instr), .instr_pc_o(b_instr_pc),
        .instr_ready_i(b_ready),
        .branch_taken_i(b_branch), .branch_target_i(b_target)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: the address of the next instruction decode should see.
    logic [31:0] exp_pc = 32'd0;
    logic        exp_no_valid = 1'b0;
    logic        hold_chk = 1'b0;
    logic [31:0] held_instr = 32'd0;
    logic [31:0] held_pc = 32'd0;
    int          delivered = 0;

    // Memory model: one outstanding read, returned after a programmable delay.
    logic        mem_out = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int unsigned mem_cnt = 0;
    int unsigned gnt_pct = 100;
    int unsigned dly_lo = 1;
    int unsigned dly_hi = 1;

    logic        obs_req, obs_gnt, obs_rvalid, obs_valid;
    logic [31:0] obs_addr, obs_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-20s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic sb_step();
        if (exp_no_valid) begin
            chk("valid_after_branch", {31'd0, instr_valid_o}, 32'd0);
            exp_no_valid = 1'b0;
        end
        if (hold_chk) begin
            chk("hold_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("hold_instr", instr_o, held_instr);
            chk("hold_pc", instr_pc_o, held_pc);
            hold_chk = 1'b0;
        end
        chk("addr_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
        if (instr_valid_o && instr_ready_i) begin
            chk("deliver_pc", instr_pc_o, exp_pc);
            chk("deliver_data", instr_o, mem_data(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (imem_req_o) begin
            chk("req_outstanding", {31'd0, mem_out}, 32'd0);
            chk("req_addr", imem_addr_o, exp_pc);
        end
        if (imem_rvalid_i) mem_out = 1'b0;
        if (imem_req_o && imem_gnt_i) begin
            mem_out  = 1'b1;
            mem_addr = imem_addr_o;
            mem_cnt  = $urandom_range(dly_hi, dly_lo);
        end
        if (branch_taken_i) begin
            exp_pc       = branch_target_i & 32'hFFFF_FFFC;
            exp_no_valid = 1'b1;
        end else if (instr_valid_o && !instr_ready_i) begin
            hold_chk   = 1'b1;
            held_instr = instr_o;
            held_pc    = instr_pc_o;
        end
        obs_req    = imem_req_o;
        obs_gnt    = imem_req_o && imem_gnt_i;
        obs_rvalid = imem_rvalid_i;
        obs_valid  = instr_valid_o;
        obs_addr   = imem_addr_o;
        obs_pc     = instr_pc_o;
    endtask

    // One clock cycle: drive at posedge+1, sample and score at negedge.
    task automatic cyc(input bit rdy, input bit br, input logic [31:0] tgt, input bit br_on_gnt);
        instr_ready_i   = rdy;
        branch_taken_i  = br;
        branch_target_i = tgt;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = $urandom;
        if (mem_out) begin
            if (mem_cnt == 1) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_data(mem_addr);
            end else begin
                mem_cnt--;
            end
        end
        #1;
        imem_gnt_i = imem_req_o && ($urandom_range(99) < gnt_pct);
        if (br_on_gnt && imem_gnt_i) branch_taken_i = 1'b1;
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit late);
        rst_ni          = 1'b0;
        imem_gnt_i      = 1'b0;
        imem_rvalid_i   = 1'b0;
        instr_ready_i   = 1'b0;
        branch_taken_i  = 1'b0;
        @(negedge clk);
        chk("reset_req", {31'd0, imem_req_o}, 32'd0);
        chk("reset_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("reset_instr", instr_o, 32'd0);
        chk("reset_instr_pc", instr_pc_o, 32'd0);
        chk("reset_addr", imem_addr_o, 32'd0);
        @(posedge clk);
        #1;
        rst_ni       = 1'b1;
        exp_pc       = 32'd0;
        exp_no_valid = 1'b0;
        hold_chk     = 1'b0;
        mem_out      = late;
        mem_cnt      = 1;
        mem_addr     = 32'h40;
    endtask

    task automatic run_until_gnt(input string tag, input bit br_on_gnt, input logic [31:0] tgt);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1'b1, 1'b0, tgt, br_on_gnt);
            found = obs_gnt;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        // Top-of-memory reset PC: the second fetch wraps to zero.
        b_ready = 1'b1;
        b_gnt   = 1'b1;
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        @(negedge clk);
        chk("t5_idle_req", {31'd0, b_req}, 32'd0);
        chk("t5_reset_addr", b_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_first_req", {31'd0, b_req}, 32'd1);
        chk("t5_first_addr", b_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        b_rvalid = 1'b1;
        b_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t5_wait_req", {31'd0, b_req}, 32'd0);
        @(posedge clk); #1;
        b_rvalid = 1'b0;
        b_gnt    = 1'b0;
        @(negedge clk);
        chk("t5_instr_pc", b_instr_pc, 32'hFFFF_FFFC);
        chk("t5_instr", b_instr, 32'hCAFE_F00D);
        chk("t5_second_addr", b_addr, 32'h0000_0000);
        @(posedge clk); #1;

        // Reset release with a zero-wait memory and decode always ready.
        gnt_pct = 100; dly_lo = 1; dly_hi = 1;
        do_reset(1'b0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t1_c1_req", {31'd0, obs_req}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t1_c2_req", {31'd0, obs_req}, 32'd1);
        chk("t1_c2_addr", obs_addr, 32'h0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t1_c3_req", {31'd0, obs_req}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t1_c4_addr", obs_addr, 32'h4);
        chk("t1_c4_instr_pc", obs_pc, 32'h0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t1_c6_addr", obs_addr, 32'h8);
        chk("t1_c6_instr_pc", obs_pc, 32'h4);

        // Decode stalls with a full buffer, then resumes.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        chk("t2_stall_valid", {31'd0, obs_valid}, 32'd1);
        chk("t2_stall_req", {31'd0, obs_req}, 32'd0);
        held_pc = obs_pc;
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t2_resume_req", {31'd0, obs_req}, 32'd1);
        chk("t2_resume_addr", obs_addr, held_pc + 32'd4);

        // Branch while waiting; the response arrives two cycles later.
        dly_lo = 3; dly_hi = 3;
        run_until_gnt("t3_grant_seen", 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'h100, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t3_no_valid_a", {31'd0, obs_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t3_rvalid_seen", {31'd0, obs_rvalid}, 32'd1);
        chk("t3_no_valid_b", {31'd0, obs_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t3_redirect_req", {31'd0, obs_req}, 32'd1);
        chk("t3_redirect_addr", obs_addr, 32'h100);
        chk("t3_no_valid_c", {31'd0, obs_valid}, 32'd0);

        // Branch in the same cycle as the grant; unaligned target.
        dly_lo = 1; dly_hi = 1;
        run_until_gnt("t4_grant_seen", 1'b1, 32'h203);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t4_squash_req", {31'd0, obs_req}, 32'd0);
        chk("t4_squash_valid", {31'd0, obs_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t4_target_req", {31'd0, obs_req}, 32'd1);
        chk("t4_target_addr", obs_addr, 32'h200);
        chk("t4_no_valid", {31'd0, obs_valid}, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);

        // Reset during WAIT; the stale response lands during IDLE.
        dly_lo = 3; dly_hi = 3;
        run_until_gnt("t6_grant_seen", 1'b0, 32'd0);
        dly_lo = 1; dly_hi = 1;
        do_reset(1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t6_late_rvalid", {31'd0, obs_rvalid}, 32'd1);
        chk("t6_idle_req", {31'd0, obs_req}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t6_first_req", {31'd0, obs_req}, 32'd1);
        chk("t6_first_addr", obs_addr, 32'h0);
        chk("t6_valid_a", {31'd0, obs_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t6_valid_b", {31'd0, obs_valid}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t6_valid_c", {31'd0, obs_valid}, 32'd1);
        chk("t6_instr_pc", obs_pc, 32'h0);

        // Randomized traffic against the stream scoreboard.
        gnt_pct = 60; dly_lo = 1; dly_hi = 3;
        delivered = 0;
        for (int i = 0; i < 1500; i++) begin
            bit          rdy;
            bit          br;
            bit          bog;
            logic [31:0] tgt;
            rdy = ($urandom_range(99) < 70);
            br  = ($urandom_range(99) < 6);
            bog = ($urandom_range(99) < 8);
            if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else tgt = $urandom & 32'h0000_0FFF;
            cyc(rdy, br, tgt, bog);
        end
        chk("rand_progress", {31'd0, delivered >= 100}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
